// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_FRAME_LEN = 11;
    // start + parity + stop surround the data bits
    localparam int         PS2_DATA_BITS = PS2_FRAME_LEN - 3;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-FF synchronizer, stability filter and
// one-cycle strobe on each falling edge of the filtered level.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    output logic fall
);
    import ps2_pkg::*;

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the filtered level; flip once FILTER_LEN seen.
    always_comb begin
        filt_d = filt_q;
        fall_d = 1'b0;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and filter state; idle-high line resets to the high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= ps2_clk;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver delivering one scan-code byte per frame.
// Optional macro PS2_BREAK_FILTER_EN: swallow 8'hF0 and the byte after it
// so a keypress yields a single got_data strobe; break_flag then stays 0.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a falling clock)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and delivering the byte
module ps2_scan_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       got_data,
    output logic       break_flag,
    output logic       frame_err
);
    import ps2_pkg::*;

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic          fall;
    logic          dsync1_q, dsync2_q;
    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          got_data_q, got_data_d;
    logic          break_flag_q, break_flag_d;
    logic          frame_err_q, frame_err_d;
    logic          pend_q, pend_d;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .fall    (fall)
    );

    // Frame sequencing, timeout and break bookkeeping; all outputs are registered.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        scan_code_d  = scan_code_q;
        got_data_d   = 1'b0;
        break_flag_d = 1'b0;
        frame_err_d  = 1'b0;
        pend_d       = pend_q;

        if (fall || state_q == IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall && !dsync2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {dsync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = dsync2_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (dsync2_q && odd_parity_ok(shift_q, parity_q)) begin
`ifdef PS2_BREAK_FILTER_EN
                        // the byte following a break code is the released key: drop both
                        if (pend_q) begin
                            pend_d = 1'b0;
                        end else if (shift_q == PS2_BREAK) begin
                            pend_d = 1'b1;
                        end else begin
                            got_data_d  = 1'b1;
                            scan_code_d = shift_q;
                        end
`else
                        got_data_d   = 1'b1;
                        scan_code_d  = shift_q;
                        break_flag_d = pend_q;
                        pend_d       = (shift_q == PS2_BREAK);
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        pend_d      = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall arriving on the terminal count keeps the frame alive.
        if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            pend_d      = 1'b0;
        end
    end

    // State registers plus data-line synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsync1_q     <= 1'b1;
            dsync2_q     <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            scan_code_q  <= '0;
            got_data_q   <= 1'b0;
            break_flag_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            dsync1_q     <= ps2_data;
            dsync2_q     <= dsync1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            scan_code_q  <= scan_code_d;
            got_data_q   <= got_data_d;
            break_flag_q <= break_flag_d;
            frame_err_q  <= frame_err_d;
            pend_q       <= pend_d;
        end
    end

    assign scan_code  = scan_code_q;
    assign got_data   = got_data_q;
    assign break_flag = break_flag_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: fixed frame table, hand-written
// corner sequences and randomized frames against a byte-level reference model.
module tb_ps2_scan_receiver;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 1000;
    // Short PS/2 bit period keeps the whole run well inside the cycle budget.
    localparam int HALF_BIT    = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       got_data;
    logic       break_flag;
    logic       frame_err;

    ps2_scan_receiver #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .got_data   (got_data),
        .break_flag (break_flag),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the inactive edge.
    int         got_cnt = 0;
    int         err_cnt = 0;
    int         flag_viol = 0;
    logic [7:0] last_code = 8'h00;
    logic       last_flag = 1'b0;
    int         last_got_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (got_data) begin
                got_cnt      = got_cnt + 1;
                last_code    = scan_code;
                last_flag    = break_flag;
                last_got_cyc = cyc;
            end else if (break_flag) begin
                flag_viol = flag_viol + 1;
            end
            if (frame_err) err_cnt = err_cnt + 1;
        end
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit pf, input bit st);
        return {st, (~^b) ^ pf, b, 1'b0};
    endfunction

    // Drives the first n bits of a frame, device-to-host timing.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF_BIT);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF_BIT);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] bits);
        send_bits(bits, 11);
        wait_cyc(20);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_got;
        logic [7:0] exp_code;
        bit         exp_err;
    } vec_t;

    vec_t vecs[6];

    // Reference model state for the random phase.
    bit         m_pend;
    logic [7:0] m_code;

    initial begin
        int g0, e0;
        logic [10:0] fr;
        logic [7:0]  b;
        bit          valid, exp_got, exp_flag, exp_err;

        vecs[0] = '{8'h73, 1'b0, 1'b0, 1'b1, 8'h73, 1'b0};
        vecs[1] = '{8'h73, 1'b1, 1'b0, 1'b0, 8'h73, 1'b1};
        vecs[2] = '{8'h72, 1'b0, 1'b0, 1'b1, 8'h72, 1'b0};
        vecs[3] = '{8'hE0, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b1};
        vecs[5] = '{8'h7D, 1'b0, 1'b0, 1'b1, 8'h7D, 1'b0};

        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(2);
        check("reset_scan_code", int'(scan_code), 0);
        check("reset_got_data", int'(got_data), 0);
        check("reset_break_flag", int'(break_flag), 0);
        check("reset_frame_err", int'(frame_err), 0);

        // Fixed frame table
        for (int i = 0; i < 6; i++) begin
            g0 = got_cnt;
            e0 = err_cnt;
            send_frame(mk(vecs[i].code, vecs[i].bad_par, !vecs[i].bad_stop));
            check($sformatf("tbl%0d_got", i), got_cnt - g0, int'(vecs[i].exp_got));
            check($sformatf("tbl%0d_err", i), err_cnt - e0, int'(vecs[i].exp_err));
            check($sformatf("tbl%0d_code", i), int'(scan_code), int'(vecs[i].exp_code));
            if (vecs[i].exp_got) begin
                check($sformatf("tbl%0d_flag", i), int'(last_flag), 0);
                check($sformatf("tbl%0d_latency", i), last_got_cyc - last_fall_cyc, FILTER_LEN + 3);
            end
        end

        // Timeout after start + 3 data bits, then recovery
        g0 = got_cnt;
        e0 = err_cnt;
        send_bits(mk(8'h73, 1'b0, 1'b1), 4);
        wait_cyc(TIMEOUT_CYC - 100);
        check("tmo_not_early", err_cnt - e0, 0);
        wait_cyc(200);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_no_got", got_cnt - g0, 0);
        g0 = got_cnt;
        send_frame(mk(8'h72, 1'b0, 1'b1));
        check("tmo_recover_got", got_cnt - g0, 1);
        check("tmo_recover_code", int'(scan_code), 8'h72);

        // Make/break sequence
        g0 = got_cnt;
        e0 = err_cnt;
        send_frame(mk(8'h73, 1'b0, 1'b1));
        send_frame(mk(8'hF0, 1'b0, 1'b1));
        send_frame(mk(8'h73, 1'b0, 1'b1));
        check("brk_err", err_cnt - e0, 0);
        check("brk_code", int'(scan_code), 8'h73);
`ifdef PS2_BREAK_FILTER_EN
        check("brk_got", got_cnt - g0, 1);
        check("brk_flag", int'(last_flag), 0);
`else
        check("brk_got", got_cnt - g0, 3);
        check("brk_flag", int'(last_flag), 1);
`endif

        // Short clock glitch with data low must not start a frame
        g0 = got_cnt;
        e0 = err_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 1);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(30);
        check("glitch_quiet", (got_cnt - g0) + (err_cnt - e0), 0);
        send_frame(mk(8'h1C, 1'b0, 1'b1));
        check("glitch_got", got_cnt - g0, 1);
        check("glitch_err", err_cnt - e0, 0);
        check("glitch_code", int'(scan_code), 8'h1C);

        // Reset in the middle of a frame
        send_bits(mk(8'h55, 1'b0, 1'b1), 6);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        check("rst_mid_code", int'(scan_code), 0);
        check("rst_mid_got", int'(got_data), 0);
        check("rst_mid_flag", int'(break_flag), 0);
        check("rst_mid_err", int'(frame_err), 0);
        g0 = got_cnt;
        e0 = err_cnt;
        send_frame(mk(8'h7D, 1'b0, 1'b1));
        check("rst_recover_got", got_cnt - g0, 1);
        check("rst_recover_err", err_cnt - e0, 0);
        check("rst_recover_code", int'(scan_code), 8'h7D);

        // Random frames against the byte-level model
        m_pend = 1'b0;
        m_code = 8'h7D;
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) b = 8'hF0;
            fr = mk(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
            valid = (($countones(fr[9:1]) % 2) == 1) && fr[10];
            exp_got = 1'b0;
            exp_flag = 1'b0;
            exp_err = 1'b0;
            if (!valid) begin
                exp_err = 1'b1;
                m_pend = 1'b0;
            end else begin
`ifdef PS2_BREAK_FILTER_EN
                if (m_pend) begin
                    m_pend = 1'b0;
                end else if (b == 8'hF0) begin
                    m_pend = 1'b1;
                end else begin
                    exp_got = 1'b1;
                    m_code = b;
                end
`else
                exp_got = 1'b1;
                exp_flag = m_pend;
                m_code = b;
                m_pend = (b == 8'hF0);
`endif
            end
            g0 = got_cnt;
            e0 = err_cnt;
            send_frame(fr);
            check($sformatf("rnd%0d_got", n), got_cnt - g0, int'(exp_got));
            check($sformatf("rnd%0d_err", n), err_cnt - e0, int'(exp_err));
            check($sformatf("rnd%0d_code", n), int'(scan_code), int'(m_code));
            if (exp_got) check($sformatf("rnd%0d_flag", n), int'(last_flag), int'(exp_flag));
        end

        check("break_flag_idle", flag_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
